// File: rtl/sprite_fetch_arbiter_if.sv
// Renderer-side bundle of the sprite fetch arbiter: per-sprite requests and
// addresses in, one-hot grant plus tagged fetched byte out.
interface sprite_fetch_arbiter_if #(
  parameter int NUM_SPRITES = 4
) ();
  logic [NUM_SPRITES-1:0]   req;
  logic [8*NUM_SPRITES-1:0] req_addr;
  logic [NUM_SPRITES-1:0]   gnt;
  logic [7:0]               data_out;
  logic [NUM_SPRITES-1:0]   data_valid;

  modport master (
    output req,
    output req_addr,
    input  gnt,
    input  data_out,
    input  data_valid
  );

  modport slave (
    input  req,
    input  req_addr,
    output gnt,
    output data_out,
    output data_valid
  );
endinterface

// File: rtl/sprite_fetch_arbiter.sv
// Round-robin arbiter sharing one sprite bitmap ROM among NUM_SPRITES renderers,
// with a per-scanline fetch budget and a per-frame sticky overflow flag.
module sprite_fetch_arbiter #(
  parameter int NUM_SPRITES = 4,
  parameter int LINE_BUDGET = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   hsync,
  input  logic                   vsync,
  sprite_fetch_arbiter_if.slave  bus,
  output logic [7:0]             rom_addr,
  input  logic [7:0]             rom_bits,
  output logic                   busy,
  output logic                   overflow
);

  localparam int         PW     = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
  localparam logic [7:0] BUDGET = 8'(LINE_BUDGET);

  function automatic logic [NUM_SPRITES-1:0] onehot(input logic [PW-1:0] idx);
    return {{(NUM_SPRITES-1){1'b0}}, 1'b1} << idx;
  endfunction

  function automatic logic [PW-1:0] ptr_after(input logic [PW-1:0] w);
    return PW'((int'(w) + 1) % NUM_SPRITES);
  endfunction

  logic [PW-1:0] rr_ptr_q, rr_ptr_d, sel_a_q, sel_a_d, sel_d_q, sel_d_d;
  logic [7:0]    fetch_count_q, fetch_count_d;
  logic [7:0]    rom_addr_q, rom_addr_d, data_out_q, data_out_d;
  logic          va_q, va_d, vd_q, vd_d;
  logic          overflow_q, overflow_d;
  logic          hsync_q, hsync_d, vsync_q, vsync_d;

  logic [PW-1:0] win_s;
  logic [PW-1:0] idx_s;
  logic          found_s, hit_s, grant_s, eligible_s;
  logic          hsync_rise_s, vsync_rise_s;

  // Round-robin scan starting at rr_ptr; first requester found wins.
  always_comb begin
    win_s   = '0;
    idx_s   = '0;
    hit_s   = 1'b0;
    found_s = 1'b0;
    for (int k = 0; k < NUM_SPRITES; k++) begin
      idx_s   = PW'((int'(rr_ptr_q) + k) % NUM_SPRITES);
      hit_s   = bus.req[idx_s] & ~found_s;
      win_s   = hit_s ? idx_s : win_s;
      found_s = found_s | hit_s;
    end
  end

  // Grant qualification, budget accounting and pipeline next-state.
  always_comb begin
    eligible_s   = reset & (fetch_count_q < BUDGET);
    grant_s      = eligible_s & found_s;
    hsync_rise_s = hsync & ~hsync_q;
    vsync_rise_s = vsync & ~vsync_q;

    bus.gnt       = grant_s ? onehot(win_s) : '0;
    rr_ptr_d      = grant_s ? ptr_after(win_s) : rr_ptr_q;
    // An hsync rise restarts the line count, including a grant taken on that cycle.
    fetch_count_d = hsync_rise_s ? {7'd0, grant_s} : (fetch_count_q + {7'd0, grant_s});
    overflow_d    = vsync_rise_s ? 1'b0
                  : (overflow_q | ((|bus.req) & (fetch_count_q == BUDGET)));

    va_d       = grant_s;
    sel_a_d    = grant_s ? win_s : sel_a_q;
    rom_addr_d = grant_s ? bus.req_addr[{win_s, 3'b000} +: 8] : rom_addr_q;
    vd_d       = va_q;
    sel_d_d    = sel_a_q;
    data_out_d = va_q ? rom_bits : data_out_q;
    hsync_d    = hsync;
    vsync_d    = vsync;
  end

  // State registers with synchronous active-low reset; in-flight fetches are dropped.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_ptr_q      <= '0;
      sel_a_q       <= '0;
      sel_d_q       <= '0;
      fetch_count_q <= 8'd0;
      rom_addr_q    <= 8'd0;
      data_out_q    <= 8'd0;
      va_q          <= 1'b0;
      vd_q          <= 1'b0;
      overflow_q    <= 1'b0;
      hsync_q       <= 1'b0;
      vsync_q       <= 1'b0;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      sel_a_q       <= sel_a_d;
      sel_d_q       <= sel_d_d;
      fetch_count_q <= fetch_count_d;
      rom_addr_q    <= rom_addr_d;
      data_out_q    <= data_out_d;
      va_q          <= va_d;
      vd_q          <= vd_d;
      overflow_q    <= overflow_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
    end
  end

  assign rom_addr       = rom_addr_q;
  assign bus.data_out   = data_out_q;
  assign bus.data_valid = vd_q ? onehot(sel_d_q) : '0;
  assign busy           = va_q | vd_q;
  assign overflow       = overflow_q;

endmodule

// File: doc/sprite_fetch_arbiter.md
Name: sprite_fetch_arbiter

Overview:
- Shares one combinational sprite bitmap ROM (8-bit address, 8-bit data) among NUM_SPRITES sprite renderers.
- Each renderer posts a line-fetch request with its ROM address. The arbiter grants one requester per cycle, round-robin, drives the shared ROM address, and returns the fetched byte tagged to the winner.
- Enforces a per-scanline fetch budget counted from hsync rising edge, and flags per-frame overflow.
- Sits between the sprite renderers and the sprite bitmap ROM in the top-level video pipeline.

Parameters:
- NUM_SPRITES, 4, number of requesters (2..8).
- LINE_BUDGET, 64, max ROM fetches granted per scanline (1..255).

Ports:
- clk  in  1  pixel clock.
- reset  in  1  synchronous, active-low reset (asserted when 0, sampled on posedge clk).
- hsync  in  1  horizontal sync from the hvsync generator.
- vsync  in  1  vertical sync from the hvsync generator.
- req  in  NUM_SPRITES  per-sprite fetch request.
- req_addr  in  8*NUM_SPRITES  flattened ROM addresses; sprite i uses bits [8i+7:8i].
- gnt  out  NUM_SPRITES  one-hot grant, combinational, same cycle as accepted request.
- rom_addr  out  8  registered address to the shared ROM.
- rom_bits  in  8  ROM data, combinational from rom_addr.
- data_out  out  8  registered fetched byte.
- data_valid  out  NUM_SPRITES  one-hot; marks the owner of data_out for one cycle.
- busy  out  1  a fetch is in flight (address or data stage valid).
- overflow  out  1  sticky: a request was refused because the budget was exhausted.

Behaviour:
- Reset (reset==0 at posedge): rom_addr=0, data_out=0, data_valid=0, overflow=0, rr_ptr=0, fetch_count=0, both pipeline valids=0, hsync_q=0, vsync_q=0. In-flight fetches are dropped; no data_valid is emitted for them.
- Arbitration, cycle t:
  - Eligible when reset==1 and fetch_count < LINE_BUDGET.
  - Winner w = first i with req[i]=1, scanning rr_ptr, rr_ptr+1, ... mod NUM_SPRITES.
  - gnt[w]=1 in cycle t, combinational. gnt is all-zero when no request or not eligible.
- Handshake:
  - Requester holds req and its addr stable until it sees gnt.
  - A req still high in the cycle after gnt counts as a new request.
  - Dropping req before gnt is legal (request withdrawn).
- Pipeline:
  - Posedge ending cycle t: rom_addr<=req_addr[w], sel_a<=w, va<=1. Otherwise va<=0 and rom_addr holds.
  - Cycle t+1: ROM produces rom_bits.
  - Posedge ending t+1: data_out<=rom_bits, sel_d<=sel_a, vd<=va.
  - Cycle t+2: data_valid = vd ? onehot(sel_d) : 0. data_out holds last value when vd=0.
  - Latency from grant to data_valid: 2 cycles. Throughput: one grant per cycle; back-to-back grants are legal.
- rr_ptr: on grant, rr_ptr <= (w+1) mod NUM_SPRITES; unchanged otherwise. Width is clog2(NUM_SPRITES), minimum 1.
- Budget:
  - hsync_q is registered each cycle; hsync rising = hsync & ~hsync_q.
  - On rising edge: fetch_count <= (grant this cycle ? 1 : 0).
  - Otherwise fetch_count increments by 1 on each grant; it never exceeds LINE_BUDGET, so the 8-bit count cannot wrap.
- Overflow:
  - Set when |req and fetch_count==LINE_BUDGET in the same cycle.
  - Cleared on vsync rising edge (vsync & ~vsync_q). If set and clear coincide, clear wins.
  - Not cleared by hsync.
- busy = va | vd.

Test Plan:
- Single sprite: req[0]=1, addr 0x23 for one cycle -> gnt[0] same cycle; rom_addr=0x23 next cycle; data_out=ROM[0x23] with data_valid=0001 two cycles after gnt.
- Round-robin: NUM_SPRITES=4, req=1111 held continuously, each requester dropping req after its own grant -> grants in order 0,1,2,3. Repeat with rr_ptr=2 -> order 2,3,0,1. data_valid sequence matches grant order, each 2 cycles after its grant.
- Budget: LINE_BUDGET=3, req[1] held high for 10 cycles after an hsync rise -> exactly 3 grants, then gnt=0 and overflow=1. Next hsync rise -> grants resume; overflow stays 1 until vsync rise, then 0.
- hsync rise coincident with a grant -> fetch_count=1 afterwards; only LINE_BUDGET-1 further grants on that line.
- Reset mid-fetch: assert reset==0 in the cycle after a grant -> no data_valid emitted; all outputs 0. After release, req[3] is granted first only if no lower rr_ptr-ordered request is present (rr_ptr=0).
- Withdrawal: req[2] raised while budget exhausted, then dropped before the next hsync -> no gnt[2], no data_valid; overflow=1.
